ta_param_writer: RTL and testbench

Parameter-buffer writer for the PVR tile-accelerator path. Takes one polygon header (ISP/TSP/TEX words) plus a stream of up to 8 strip vertices and writes them into VRAM in the ISP parameter layout that the ISP-side parser walks: header, then x, y, z, optional UV, base colour, optional offset colour per vertex. When the polygon is finished it emits the matching triangle-strip object-list word (strip mask, skip, parameter word address) for the OL builder.

---
 rtl/pvr_param_pkg.sv | 45 ++++
 rtl/ta_vtx_word_sel.sv | 42 ++++
 rtl/ta_param_writer.sv | 158 +++++++++++++++
 tb/tb_ta_param_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pvr_param_pkg.sv
// rtl/pvr_param_pkg.sv - shared PVR parameter-format constants, writer state and vertex record
package pvr_param_pkg;

  localparam int ISP_TEXTURE = 25;
  localparam int ISP_OFFSET  = 24;
  localparam int ISP_UV16    = 22;

  localparam int OL_MASK_HI  = 30;
  localparam int OL_MASK_LO  = 25;
  localparam int OL_SHADOW   = 24;
  localparam int OL_SKIP_HI  = 23;
  localparam int OL_SKIP_LO  = 21;
  localparam int OL_ADDR_HI  = 20;

  localparam logic [3:0] MAX_VTX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_VWAIT,
    ST_VWR,
    ST_EMIT
  } wr_state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] u0;
    logic [31:0] v0;
    logic [31:0] base_col;
    logic [31:0] off_col;
  } vtx_t;

  // Triangle k of an n-vertex strip owns mask field bit 5-k (OL bit 30-k).
  function automatic logic [5:0] strip_mask(input logic [3:0] n);
    logic [5:0] m;
    m = '0;
    for (int k = 0; k < 6; k++) begin
      if (k + 3 <= int'({28'd0, n})) m[5-k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ta_vtx_word_sel.sv
// rtl/ta_vtx_word_sel.sv - picks vertex word idx in ISP parameter order and reports words per vertex
module ta_vtx_word_sel
  import pvr_param_pkg::*;
(
  input  vtx_t        vtx,
  input  logic        texture,
  input  logic        offset,
  input  logic        uv16,
  input  logic [2:0]  idx,
  output logic [31:0] word,
  output logic [2:0]  n_words,
  output logic [2:0]  skip
);

  logic [2:0] uv_words;
  logic [2:0] rel;

  assign uv_words = texture ? (uv16 ? 3'd1 : 3'd2) : 3'd0;
  assign skip     = uv_words + 3'd1 + {2'b00, offset};
  assign n_words  = skip + 3'd3;
  assign rel      = idx - 3'd3;

  // Layout after x,y,z: [uv words] base_col [off_col]
  always_comb begin
    word = '0;
    if (idx < 3'd3) begin
      case (idx)
        3'd0:    word = vtx.x;
        3'd1:    word = vtx.y;
        default: word = vtx.z;
      endcase
    end else if (rel < uv_words) begin
      if (uv16) word = {vtx.u0[31:16], vtx.v0[31:16]};
      else      word = (rel == 3'd0) ? vtx.u0 : vtx.v0;
    end else if (rel == uv_words) begin
      word = vtx.base_col;
    end else begin
      word = vtx.off_col;
    end
  end

endmodule

// File: rtl/ta_param_writer.sv
// rtl/ta_param_writer.sv - writes polygon header and strip vertices to VRAM, emits strip OL word
module ta_param_writer
  import pvr_param_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [23:0] param_base,
  input  logic        param_start,
  input  logic        poly_start,
  input  logic [31:0] hdr_isp,
  input  logic [31:0] hdr_tsp,
  input  logic [31:0] hdr_tex,
  input  logic        vtx_valid,
  output logic        vtx_ready,
  input  logic        vtx_last,
  input  logic [31:0] vtx_x,
  input  logic [31:0] vtx_y,
  input  logic [31:0] vtx_z,
  input  logic [31:0] vtx_u0,
  input  logic [31:0] vtx_v0,
  input  logic [31:0] vtx_base_col,
  input  logic [31:0] vtx_off_col,
  output logic        ta_vram_wr,
  output logic [23:0] ta_vram_addr,
  output logic [31:0] ta_vram_dout,
  input  logic        ta_vram_wait,
  output logic        ol_valid,
  output logic [31:0] ol_word,
  output logic        strip_err,
  output logic        busy,
  output logic [23:0] param_ptr
);

  wr_state_t   state, state_nxt;
  logic [31:0] isp_q, tsp_q, tex_q;
  vtx_t        vtx_q;
  logic [23:0] poly_addr;
  logic [2:0]  word_idx;
  logic [3:0]  vcount;
  logic        last_q;
  logic        cap_err_q;
  logic [31:0] vtx_word;
  logic [2:0]  n_words;
  logic [2:0]  skip;
  logic [31:0] wr_data;
  logic        group_end;
  logic        accept;

  ta_vtx_word_sel u_word_sel (
    .vtx     (vtx_q),
    .texture (isp_q[ISP_TEXTURE]),
    .offset  (isp_q[ISP_OFFSET]),
    .uv16    (isp_q[ISP_UV16]),
    .idx     (word_idx),
    .word    (vtx_word),
    .n_words (n_words),
    .skip    (skip)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    vtx_ready  = 1'b0;
    ta_vram_wr = 1'b0;
    wr_data    = '0;
    group_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (poly_start) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        ta_vram_wr = 1'b1;
        case (word_idx)
          3'd0:    wr_data = isp_q;
          3'd1:    wr_data = tsp_q;
          default: wr_data = tex_q;
        endcase
        group_end = (word_idx == 3'd2);
        if (!ta_vram_wait && group_end) state_nxt = ST_VWAIT;
      end
      ST_VWAIT: begin
        vtx_ready = 1'b1;
        if (vtx_valid) state_nxt = ST_VWR;
      end
      ST_VWR: begin
        ta_vram_wr = 1'b1;
        wr_data    = vtx_word;
        group_end  = (word_idx == n_words - 3'd1);
        if (!ta_vram_wait && group_end) state_nxt = last_q ? ST_EMIT : ST_VWAIT;
      end
      ST_EMIT: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept       = ta_vram_wr && !ta_vram_wait;
  assign ta_vram_addr = ta_vram_wr ? param_ptr : 24'd0;
  assign ta_vram_dout = wr_data;
  assign busy         = (state != ST_IDLE);
  assign ol_valid     = (state == ST_EMIT) && (vcount >= 4'd3);
  assign strip_err    = (state == ST_EMIT) && ((vcount < 4'd3) || cap_err_q);
  assign ol_word      = ol_valid ? {1'b0, strip_mask(vcount), 1'b0, skip, poly_addr[22:2]} : 32'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      param_ptr <= '0;
      poly_addr <= '0;
      isp_q     <= '0;
      tsp_q     <= '0;
      tex_q     <= '0;
      vtx_q     <= '0;
      word_idx  <= '0;
      vcount    <= '0;
      last_q    <= 1'b0;
      cap_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (param_start) param_ptr <= param_base;
          if (poly_start) begin
            isp_q     <= hdr_isp;
            tsp_q     <= hdr_tsp;
            tex_q     <= hdr_tex;
            poly_addr <= param_start ? param_base : param_ptr;
            word_idx  <= '0;
            vcount    <= '0;
            last_q    <= 1'b0;
            cap_err_q <= 1'b0;
          end
        end
        ST_HDR, ST_VWR: begin
          if (accept) begin
            param_ptr <= param_ptr + 24'd4;
            word_idx  <= group_end ? 3'd0 : word_idx + 3'd1;
          end
        end
        ST_VWAIT: begin
          if (vtx_valid) begin
            vtx_q     <= '{vtx_x, vtx_y, vtx_z, vtx_u0, vtx_v0, vtx_base_col, vtx_off_col};
            vcount    <= vcount + 4'd1;
            // The eighth vertex closes the strip whether or not it was flagged last.
            last_q    <= vtx_last || (vcount == MAX_VTX - 4'd1);
            cap_err_q <= !vtx_last && (vcount == MAX_VTX - 4'd1);
          end
        end
        ST_EMIT: begin
          if (vcount < 4'd3) param_ptr <= poly_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ta_param_writer.sv
// tb/tb_ta_param_writer.sv - randomized self-checking bench for ta_param_writer
module tb_ta_param_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [23:0] param_base;
  logic        param_start, poly_start;
  logic [31:0] hdr_isp, hdr_tsp, hdr_tex;
  logic        vtx_valid, vtx_ready, vtx_last;
  logic [31:0] vtx_x, vtx_y, vtx_z, vtx_u0, vtx_v0, vtx_base_col, vtx_off_col;
  logic        ta_vram_wr;
  logic [23:0] ta_vram_addr;
  logic [31:0] ta_vram_dout;
  logic        ta_vram_wait;
  logic        ol_valid;
  logic [31:0] ol_word;
  logic        strip_err, busy;
  logic [23:0] param_ptr;

  ta_param_writer dut (
    .clock(clock), .reset_n(reset_n), .param_base(param_base), .param_start(param_start),
    .poly_start(poly_start), .hdr_isp(hdr_isp), .hdr_tsp(hdr_tsp), .hdr_tex(hdr_tex),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_last(vtx_last),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z), .vtx_u0(vtx_u0), .vtx_v0(vtx_v0),
    .vtx_base_col(vtx_base_col), .vtx_off_col(vtx_off_col),
    .ta_vram_wr(ta_vram_wr), .ta_vram_addr(ta_vram_addr), .ta_vram_dout(ta_vram_dout),
    .ta_vram_wait(ta_vram_wait), .ol_valid(ol_valid), .ol_word(ol_word),
    .strip_err(strip_err), .busy(busy), .param_ptr(param_ptr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [23:0] got_addr[$];
  logic [31:0] got_data[$];
  int          ol_cnt, err_cnt, ol_err_coinc, stall_bad, stall_cycles, force_cnt, wmode;
  logic [31:0] ol_seen, stall_dout;
  logic [23:0] force_addr, prev_addr;
  logic [31:0] prev_dout;
  logic        stalled_prev = 1'b0;

  logic [31:0] vx[8], vy[8], vz[8], vu[8], vv[8], vb[8], vo[8];
  logic [31:0] exp_q[$];
  logic [23:0] exp_base, exp_ptr, model_ptr;
  logic [31:0] exp_ol;
  bit          exp_olv, exp_err, first_ok;

  // VRAM side: wait generation, stall-hold observation and accepted-word capture.
  always @(negedge clock) begin
    logic w;
    case (wmode)
      1:       w = ($urandom_range(0, 2) == 0);
      2:       w = ta_vram_wr && (ta_vram_addr == force_addr) && (force_cnt < 4);
      default: w = 1'b0;
    endcase
    if (wmode == 2 && w) force_cnt++;
    ta_vram_wait = w;
    if (stalled_prev && (!ta_vram_wr || ta_vram_addr != prev_addr || ta_vram_dout != prev_dout))
      stall_bad++;
    if (ta_vram_wr && w) begin
      if (!stalled_prev) stall_dout = ta_vram_dout;
      stall_cycles++;
    end
    stalled_prev = ta_vram_wr && w;
    prev_addr    = ta_vram_addr;
    prev_dout    = ta_vram_dout;
    if (ta_vram_wr && !w) begin
      got_addr.push_back(ta_vram_addr);
      got_data.push_back(ta_vram_dout);
    end
    if (ol_valid) begin
      ol_cnt++;
      ol_seen = ol_word;
      if (strip_err) ol_err_coinc++;
    end
    if (strip_err) err_cnt++;
  end

  // Reference: expected word stream, pointer and OL entry from the parameter format rules.
  task automatic model(input logic [23:0] base, input logic [31:0] isp, input int nv, input bit give_last);
    bit tex, off, uv16;
    logic [31:0] mask, skip;
    tex  = isp[25];
    off  = isp[24];
    uv16 = isp[22];
    exp_q.delete();
    exp_q.push_back(isp);
    exp_q.push_back(hdr_tsp);
    exp_q.push_back(hdr_tex);
    for (int v = 0; v < nv; v++) begin
      exp_q.push_back(vx[v]);
      exp_q.push_back(vy[v]);
      exp_q.push_back(vz[v]);
      if (tex) begin
        if (uv16) exp_q.push_back({vu[v][31:16], vv[v][31:16]});
        else begin
          exp_q.push_back(vu[v]);
          exp_q.push_back(vv[v]);
        end
      end
      exp_q.push_back(vb[v]);
      if (off) exp_q.push_back(vo[v]);
    end
    exp_base = base;
    exp_olv  = (nv >= 3);
    exp_err  = (nv < 3) || (nv == 8 && !give_last);
    exp_ptr  = exp_olv ? base + 24'(4 * exp_q.size()) : base;
    skip     = (tex ? (uv16 ? 1 : 2) : 0) + 1 + (off ? 1 : 0);
    mask     = 0;
    for (int k = 0; k <= nv - 3; k++) mask = mask | (32'd1 << (30 - k));
    exp_ol   = exp_olv ? (mask | (skip << 21) | (({8'd0, base} >> 2) & 32'h001F_FFFF)) : 32'd0;
  endtask

  task automatic drive_poly(input bit load, input logic [23:0] base, input logic [31:0] isp,
                            input int nv, input bit give_last);
    int n;
    got_addr.delete();
    got_data.delete();
    ol_cnt = 0; err_cnt = 0; ol_err_coinc = 0; stall_bad = 0; stall_cycles = 0; force_cnt = 0;
    ol_seen = 32'd0; stall_dout = 32'd0;
    force_addr = base + 24'd4;
    hdr_tsp = $urandom;
    hdr_tex = $urandom;
    for (int v = 0; v < 8; v++) begin
      vx[v] = $urandom; vy[v] = $urandom; vz[v] = $urandom; vu[v] = $urandom;
      vv[v] = $urandom; vb[v] = $urandom; vo[v] = $urandom;
    end
    model(base, isp, nv, give_last);
    @(negedge clock);
    param_base  = load ? base : 24'($urandom);
    param_start = load;
    poly_start  = 1'b1;
    hdr_isp     = isp;
    @(negedge clock);
    first_ok    = ta_vram_wr && (ta_vram_addr == base) && (ta_vram_dout == isp);
    param_start = 1'b0;
    poly_start  = 1'b0;
    param_base  = 24'($urandom);
    for (int v = 0; v < nv; v++) begin
      vtx_valid = 1'b1;
      vtx_last  = give_last && (v == nv - 1);
      vtx_x = vx[v]; vtx_y = vy[v]; vtx_z = vz[v]; vtx_u0 = vu[v];
      vtx_v0 = vv[v]; vtx_base_col = vb[v]; vtx_off_col = vo[v];
      n = 0;
      while (!vtx_ready && n < 300) begin
        @(negedge clock);
        n++;
      end
      if (n >= 300) begin
        checks++; errors++;
        $display("FAIL vtx_timeout vertex %0d: vtx_ready never high within 300 cycles, required high", v);
        vtx_valid = 1'b0;
        break;
      end
      @(negedge clock);
      vtx_valid = 1'b0;
      vtx_last  = 1'b0;
      vtx_x = $urandom; vtx_y = $urandom; vtx_z = $urandom; vtx_u0 = $urandom;
      vtx_v0 = $urandom; vtx_base_col = $urandom; vtx_off_col = $urandom;
    end
    n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL busy_timeout: busy still %0b after 300 cycles, required 0", busy);
    end
    @(negedge clock);
    model_ptr = exp_ptr;
  endtask

  task automatic test_reset();
    checks++;
    if ({vtx_ready, ta_vram_wr, ta_vram_addr, ta_vram_dout, ol_valid, ol_word, strip_err, busy, param_ptr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b wr=%0b addr=%h dout=%h olv=%0b ol=%h err=%0b busy=%0b ptr=%h, required all 0",
               vtx_ready, ta_vram_wr, ta_vram_addr, ta_vram_dout, ol_valid, ol_word, strip_err, busy, param_ptr);
    end
  endtask

  task automatic test_untextured();
    int mism;
    wmode = 0;
    drive_poly(1'b1, 24'h000100, 32'h80800000, 3, 1'b1);
    checks++;
    if (!first_ok) begin errors++; $display("FAIL untex_first_word: wr=%0b addr=%h dout=%h, required 1/000100/80800000", ta_vram_wr, ta_vram_addr, ta_vram_dout); end
    checks++;
    if (got_data.size() !== 15) begin errors++; $display("FAIL untex_count: got %0d words, required 15", got_data.size()); end
    mism = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_addr[i] !== 24'h100 + 24'(4 * i) || got_data[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0) begin errors++; $display("FAIL untex_words: %0d mismatching words, required 0", mism); end
    checks++;
    if (ol_cnt !== 1 || ol_seen !== 32'h40200040) begin errors++; $display("FAIL untex_ol: cnt %0d word %h, required 1 40200040", ol_cnt, ol_seen); end
    checks++;
    if (param_ptr !== 24'h00013C || err_cnt !== 0) begin errors++; $display("FAIL untex_ptr: ptr %h err %0d, required 00013c 0", param_ptr, err_cnt); end
  endtask

  task automatic test_uv16_offset();
    int mism;
    wmode = 0;
    drive_poly(1'b1, 24'h002000, 32'h03400000, 5, 1'b1);
    checks++;
    if (got_data.size() !== 33) begin errors++; $display("FAIL uv16_count: got %0d words, required 33", got_data.size()); end
    mism = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_data[i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0 || got_data.size() < 9 || got_data[6] !== {vu[0][31:16], vv[0][31:16]}) begin
      errors++; $display("FAIL uv16_words: %0d mismatches, uv word %h, required 0 and %h", mism,
                         (got_data.size() > 6) ? got_data[6] : 32'hx, {vu[0][31:16], vv[0][31:16]});
    end
    checks++;
    if (ol_seen !== 32'h70600800 || param_ptr !== 24'h002084) begin errors++; $display("FAIL uv16_ol: ol %h ptr %h, required 70600800 002084", ol_seen, param_ptr); end
  endtask

  task automatic test_full_uv();
    logic [23:0] base;
    base = 24'($urandom) & 24'hFFFFFC;
    wmode = 1;
    drive_poly(1'b1, base, 32'h02000000, 4, 1'b1);
    checks++;
    if (got_data.size() !== 3 + 4 * 6 || got_data[6] !== vu[0] || got_data[7] !== vv[0] || got_data[8] !== vb[0]) begin
      errors++; $display("FAIL fulluv_layout: count %0d, required %0d with u0 %h v0 %h base %h at 6..8", got_data.size(), 27, vu[0], vv[0], vb[0]);
    end
    checks++;
    if (ol_seen[23:21] !== 3'd3 || ol_seen !== exp_ol || param_ptr !== exp_ptr) begin
      errors++; $display("FAIL fulluv_ol: ol %h ptr %h, required %h (skip 3) ptr %h", ol_seen, param_ptr, exp_ol, exp_ptr);
    end
  endtask

  task automatic test_wait();
    int mism;
    wmode = 2;
    drive_poly(1'b1, 24'h000400, 32'h80800000, 3, 1'b1);
    wmode = 0;
    checks++;
    if (stall_cycles !== 4 || stall_bad !== 0 || stall_dout !== hdr_tsp) begin
      errors++; $display("FAIL wait_hold: stalls %0d holdbreaks %0d dout %h, required 4 0 %h", stall_cycles, stall_bad, stall_dout, hdr_tsp);
    end
    mism = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_addr[i] !== 24'h400 + 24'(4 * i) || got_data[i] !== exp_q[i]) mism++;
    checks++;
    if (got_data.size() !== 15 || mism != 0) begin errors++; $display("FAIL wait_words: count %0d mism %0d, required 15 0", got_data.size(), mism); end
  endtask

  task automatic test_short_strip();
    logic [23:0] base;
    base = 24'h000800;
    wmode = 1;
    drive_poly(1'b1, base, {6'd0, 2'($urandom), 1'b0, 1'($urandom), 22'd0}, 2, 1'b1);
    checks++;
    if (ol_cnt !== 0 || err_cnt !== 1) begin errors++; $display("FAIL short_pulses: ol %0d err %0d, required 0 1", ol_cnt, err_cnt); end
    checks++;
    if (param_ptr !== base) begin errors++; $display("FAIL short_rewind: ptr %h, required %h", param_ptr, base); end
  endtask

  task automatic test_cap8();
    int mism;
    wmode = 1;
    drive_poly(1'b1, 24'h003000, {6'd0, 2'($urandom), 1'b0, 1'($urandom), 22'd0}, 8, 1'b0);
    checks++;
    if (ol_cnt !== 1 || (ol_seen & 32'h7E000000) !== 32'h7E000000 || ol_seen !== exp_ol) begin
      errors++; $display("FAIL cap8_ol: cnt %0d ol %h, required 1 %h", ol_cnt, ol_seen, exp_ol);
    end
    checks++;
    if (err_cnt !== 1 || ol_err_coinc !== 1) begin errors++; $display("FAIL cap8_err: err %0d coincident %0d, required 1 1", err_cnt, ol_err_coinc); end
    mism = 0;
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      if (got_data[i] !== exp_q[i]) mism++;
    checks++;
    if (got_data.size() !== exp_q.size() || mism != 0 || param_ptr !== exp_ptr) begin
      errors++; $display("FAIL cap8_words: count %0d mism %0d ptr %h, required %0d 0 %h", got_data.size(), mism, param_ptr, exp_q.size(), exp_ptr);
    end
  endtask

  task automatic test_random_strips();
    int mism, nv;
    logic [23:0] base;
    bit load;
    logic [31:0] isp;
    wmode = 1;
    for (int it = 0; it < 6; it++) begin
      load = (it == 0) || (it == 3);
      base = load ? ((it == 3) ? 24'hFFFFE0 : (24'($urandom) & 24'hFFFFFC)) : model_ptr;
      nv   = $urandom_range(3, 8);
      isp  = {6'd0, 2'($urandom), 1'b0, 1'($urandom), 22'($urandom)};
      drive_poly(load, base, isp, nv, 1'b1);
      mism = 0;
      for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
        if (got_addr[i] !== base + 24'(4 * i) || got_data[i] !== exp_q[i]) mism++;
      checks++;
      if (got_data.size() !== exp_q.size() || mism != 0) begin
        errors++; $display("FAIL rand%0d_words: count %0d mism %0d, required %0d 0", it, got_data.size(), mism, exp_q.size());
      end
      checks++;
      if (ol_cnt !== 1 || ol_seen !== exp_ol || err_cnt !== 0 || param_ptr !== exp_ptr) begin
        errors++; $display("FAIL rand%0d_ol: cnt %0d ol %h err %0d ptr %h, required 1 %h 0 %h", it, ol_cnt, ol_seen, err_cnt, param_ptr, exp_ol, exp_ptr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    wmode = 0;
    @(negedge clock);
    param_base = 24'h000500; param_start = 1'b1; poly_start = 1'b1; hdr_isp = 32'h80800000;
    @(negedge clock);
    param_start = 1'b0; poly_start = 1'b0;
    vtx_valid = 1'b1; vtx_last = 1'b0;
    n = 0;
    while (!vtx_ready && n < 50) begin @(negedge clock); n++; end
    @(negedge clock);
    vtx_valid = 1'b0;
    ol_cnt = 0; err_cnt = 0;
    checks++;
    if (ta_vram_wr !== 1'b1) begin errors++; $display("FAIL rstmid_precond: wr %0b, required 1 (vertex write phase)", ta_vram_wr); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({vtx_ready, ta_vram_wr, ta_vram_addr, ta_vram_dout, ol_valid, ol_word, strip_err, busy, param_ptr} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: wr=%0b addr=%h dout=%h busy=%0b ptr=%h, required all 0", ta_vram_wr, ta_vram_addr, ta_vram_dout, busy, param_ptr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (ol_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL rstmid_no_ol: ol %0d err %0d, required 0 0", ol_cnt, err_cnt); end
    model_ptr = 24'd0;
    drive_poly(1'b0, 24'd0, 32'h80800000, 3, 1'b1);
    checks++;
    if (got_addr.size() == 0 || got_addr[0] !== 24'd0 || ol_seen !== 32'h40200000 || param_ptr !== 24'h00003C) begin
      errors++; $display("FAIL rstmid_restart: first addr %h ol %h ptr %h, required 000000 40200000 00003c",
                         (got_addr.size() > 0) ? got_addr[0] : 24'hx, ol_seen, param_ptr);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wmode = 0;
    param_base = '0; param_start = 1'b0; poly_start = 1'b0;
    hdr_isp = '0; hdr_tsp = '0; hdr_tex = '0;
    vtx_valid = 1'b0; vtx_last = 1'b0;
    vtx_x = '0; vtx_y = '0; vtx_z = '0; vtx_u0 = '0; vtx_v0 = '0; vtx_base_col = '0; vtx_off_col = '0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_untextured();
    test_uv16_offset();
    test_full_uv();
    test_wait();
    test_short_strip();
    test_cap8();
    test_random_strips();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
